// File: rtl/encode_normalizer.sv
// Strip buffer that turns a raster pixel stream into 8x8 blocks for the DCT stage.
// Optional macro ENC_LEVEL_SHIFT_EN applies the pixel-128 level shift on output.
module encode_normalizer #(
  parameter int PIXEL_BIT = 8,
  parameter int BLOCK_BIT = 3,
  parameter int IMG_W     = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PIXEL_BIT-1:0] giris_veri_i,
  input  logic                 giris_gecerli_i,
  output logic                 giris_hazir_o,
  output logic [PIXEL_BIT-1:0] dct_veri_o,
  output logic [BLOCK_BIT-1:0] dct_row_o,
  output logic [BLOCK_BIT-1:0] dct_col_o,
  output logic                 dct_gecerli_o,
  output logic                 dct_blok_son_o,
  output logic                 dct_serit_son_o,
  input  logic                 dct_hazir_i
);

  localparam int BS    = 1 << BLOCK_BIT;
  localparam int X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int BLK_W = (X_W > BLOCK_BIT) ? X_W - BLOCK_BIT : 1;
  localparam int NBLK  = IMG_W / BS;

  localparam logic [BLOCK_BIT-1:0] IDX_LAST = BLOCK_BIT'(BS - 1);
  localparam logic [X_W-1:0]       X_LAST   = X_W'(IMG_W - 1);
  localparam logic [BLK_W-1:0]     BLK_LAST = BLK_W'(NBLK - 1);

`ifdef ENC_LEVEL_SHIFT_EN
  localparam logic [PIXEL_BIT-1:0] SHIFT_MASK = PIXEL_BIT'(1) << (PIXEL_BIT - 1);
`else
  localparam logic [PIXEL_BIT-1:0] SHIFT_MASK = '0;
`endif

  typedef enum logic {FILL, DRAIN} state_t;

  logic [PIXEL_BIT-1:0] mem_q [0:BS-1][0:IMG_W-1];

  state_t               state_q, state_d;
  logic [BLOCK_BIT-1:0] wr_row_q, wr_row_d;
  logic [X_W-1:0]       wr_x_q, wr_x_d;
  logic [BLK_W-1:0]     rd_blk_q, rd_blk_d;
  logic [BLOCK_BIT-1:0] rd_row_q, rd_row_d;
  logic [BLOCK_BIT-1:0] rd_col_q, rd_col_d;
  logic [PIXEL_BIT-1:0] veri_q, veri_d;
  logic                 valid_q, valid_d;
  logic                 blok_son_q, blok_son_d;
  logic                 serit_son_q, serit_son_d;

  logic                 fill_xfer;
  logic                 out_xfer;
  logic                 load;
  logic [X_W-1:0]       rd_x;

  assign fill_xfer = (state_q == FILL) && giris_gecerli_i;
  assign out_xfer  = valid_q && dct_hazir_i;

  // Read counters always name the pixel being presented; load fetches the pixel they point to.
  always_comb begin
    state_d     = state_q;
    wr_row_d    = wr_row_q;
    wr_x_d      = wr_x_q;
    rd_blk_d    = rd_blk_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    veri_d      = veri_q;
    valid_d     = valid_q;
    blok_son_d  = blok_son_q;
    serit_son_d = serit_son_q;
    load        = 1'b0;

    case (state_q)
      FILL: begin
        if (fill_xfer) begin
          if (wr_x_q == X_LAST) begin
            wr_x_d = '0;
            if (wr_row_q == IDX_LAST) begin
              wr_row_d = '0;
              state_d  = DRAIN;
              valid_d  = 1'b1;
              rd_blk_d = '0;
              rd_row_d = '0;
              rd_col_d = '0;
              load     = 1'b1;
            end else begin
              wr_row_d = wr_row_q + 1'b1;
            end
          end else begin
            wr_x_d = wr_x_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_xfer) begin
          if (serit_son_q) begin
            state_d     = FILL;
            valid_d     = 1'b0;
            rd_blk_d    = '0;
            rd_row_d    = '0;
            rd_col_d    = '0;
            veri_d      = '0;
            blok_son_d  = 1'b0;
            serit_son_d = 1'b0;
          end else begin
            load = 1'b1;
            if (rd_col_q == IDX_LAST) begin
              rd_col_d = '0;
              if (rd_row_q == IDX_LAST) begin
                rd_row_d = '0;
                rd_blk_d = rd_blk_q + 1'b1;
              end else begin
                rd_row_d = rd_row_q + 1'b1;
              end
            end else begin
              rd_col_d = rd_col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = FILL;
    endcase

    rd_x = X_W'({rd_blk_d, rd_col_d});
    if (load) begin
      veri_d      = mem_q[rd_row_d][rd_x] ^ SHIFT_MASK;
      blok_son_d  = (rd_row_d == IDX_LAST) && (rd_col_d == IDX_LAST);
      serit_son_d = (rd_row_d == IDX_LAST) && (rd_col_d == IDX_LAST) && (rd_blk_d == BLK_LAST);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= FILL;
      wr_row_q    <= '0;
      wr_x_q      <= '0;
      rd_blk_q    <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      veri_q      <= '0;
      valid_q     <= 1'b0;
      blok_son_q  <= 1'b0;
      serit_son_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_row_q    <= wr_row_d;
      wr_x_q      <= wr_x_d;
      rd_blk_q    <= rd_blk_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      veri_q      <= veri_d;
      valid_q     <= valid_d;
      blok_son_q  <= blok_son_d;
      serit_son_q <= serit_son_d;
    end
  end

  // The strip buffer itself carries no reset; stale contents are always overwritten before a drain.
  always_ff @(posedge clk_i) begin
    if (fill_xfer) begin
      mem_q[wr_row_q][wr_x_q] <= giris_veri_i;
    end
  end

  assign giris_hazir_o   = (state_q == FILL);
  assign dct_veri_o      = veri_q;
  assign dct_row_o       = rd_row_q;
  assign dct_col_o       = rd_col_q;
  assign dct_gecerli_o   = valid_q;
  assign dct_blok_son_o  = blok_son_q;
  assign dct_serit_son_o = serit_son_q;

endmodule

// File: doc/encode_normalizer.md
Name: encode_normalizer

Overview:
Encode-side counterpart of decode_normalizer. It accepts a raster-order pixel stream and buffers one strip of 8 image rows. It then emits the strip as 8x8 blocks toward the DCT stage, with per-pixel block row/column coordinates and a block-last flag. The level shift toward the DCT (pixel minus 128) is applied on output.

Parameters:
PIXEL_BIT, 8, input pixel width (unsigned); output width is identical, two's-complement.
BLOCK_BIT, 3, width of the in-block row/column index (block is 2^BLOCK_BIT = 8 square).
IMG_W, 64, image width in pixels; must be a multiple of 8, minimum 8.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
giris_veri_i  in  PIXEL_BIT  raster pixel, unsigned
giris_gecerli_i  in  1  input valid
giris_hazir_o  out  1  input ready
dct_veri_o  out  PIXEL_BIT  output pixel (signed when shift enabled)
dct_row_o  out  BLOCK_BIT  row inside current block
dct_col_o  out  BLOCK_BIT  column inside current block
dct_gecerli_o  out  1  output valid
dct_blok_son_o  out  1  high with the last pixel (row 7, col 7) of every block
dct_serit_son_o  out  1  high with the last pixel of the last block of a strip
dct_hazir_i  in  1  downstream ready

Behaviour:
- Interface: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset: state FILL, write row/column counters 0, read block/row/column counters 0.
- Reset output values: giris_hazir_o=1 after reset; dct_gecerli_o=0; dct_blok_son_o=0; dct_serit_son_o=0; dct_veri_o, dct_row_o and dct_col_o=0.
- Storage: 8*IMG_W x PIXEL_BIT array, one strip. No double buffering.
- FILL state:
  - giris_hazir_o=1, dct_gecerli_o=0.
  - Input transfer occurs when giris_gecerli_i && giris_hazir_o.
  - Each transfer writes entry [wr_row][wr_x]. wr_x increments, wraps at IMG_W-1 to 0 and increments wr_row.
  - On the transfer with wr_row=7 and wr_x=IMG_W-1, go to DRAIN next cycle.
- DRAIN state:
  - giris_hazir_o=0. Input is stalled; giris_veri_i is ignored.
  - Output order: block b = 0 .. IMG_W/8-1. Within a block, row-major (row 0..7, col 0..7).
  - Source entry is [row][8*b+col].
- Output register:
  - dct_* are registered.
  - The first dct_gecerli_o rises exactly 1 cycle after the final FILL transfer.
  - Output transfer occurs when dct_gecerli_o && dct_hazir_i; the next element is presented the following cycle.
  - Throughput is 1 pixel/cycle with dct_hazir_i held high; no bubbles inside or between blocks.
  - While dct_gecerli_o=1 && !dct_hazir_i, all dct_* outputs hold stable.
- Flags:
  - dct_blok_son_o=1 exactly when the presented pixel has row=7, col=7.
  - dct_serit_son_o=1 additionally when b=IMG_W/8-1.
- Strip end: on transfer of the pixel with dct_serit_son_o=1, the next cycle has dct_gecerli_o=0, giris_hazir_o=1, state FILL, counters 0. Image height is unbounded; strips repeat.
- Level shift: dct_veri_o = pixel - 128, computed as pixel XOR MSB inversion. Result range -128..127; no overflow possible.
- Reset mid-operation (FILL or DRAIN): partial strip is discarded and the block returns to the reset state next cycle. Buffer contents need not be cleared.
- giris_gecerli_i may toggle freely; only accepted transfers advance counters.

Optional Feature:
ENC_LEVEL_SHIFT_EN
- Defined: dct_veri_o = pixel - 128, two's-complement.
- Undefined: dct_veri_o = raw unsigned pixel.
- Ordering, timing and flags are identical in both cases.

Test Plan:
1. IMG_W=16, shift on, dct_hazir_i=1; feed 128 pixels, value = r*16+x, gaps-free. Required output:
   - 128 outputs in 128 consecutive cycles, first one 1 cycle after the last input.
   - Output 0 = 0x80 (-128) at row0/col0. Output 8 (row1/col0) = -112. Output 64 (block 1, row0/col0) = 8-128 = -120.
   - blok_son on outputs 63 and 127; serit_son only on output 127.
2. Random giris_gecerli_i (50%): same data order as test 1. giris_hazir_o=0 for the whole DRAIN phase and 1 from the cycle after output 127.
3. Backpressure: dct_hazir_i low 3 cycles at output 10. The value -128+r*16+x with row1/col2 is held for 4 cycles with all fields unchanged; no loss or duplication.
4. Two consecutive strips with values offset by +100 in strip 2. Strip 2 output 0 = 100-128 = -28; serit_son fires once per strip.
5. rst_i pulse after 40 outputs of DRAIN. Next cycle dct_gecerli_o=0 and giris_hazir_o=1; a fresh strip then drains from row0/col0, block 0.
6. ENC_LEVEL_SHIFT_EN undefined, rerun test 1. Output 0 = 0, output 64 = 8, output 127 = 127.
